// File: rtl/cm0_ctrl_pkg.sv
// Shared definitions for the Cortex-M0 control sequencer.
// Holds the FSM state encodings, the memory address-source codes and the
// fixed reset-vector addresses used by the bus interface.
package cm0_ctrl_pkg;

  // Architectural FSM encoding; HALT and FAULT share code 7 and are told
  // apart by the sticky fault flag.
  typedef enum logic [2:0] {
    ST_RST_SP     = 3'd0,
    ST_RST_PC     = 3'd1,
    ST_FETCH      = 3'd2,
    ST_DECODE     = 3'd3,
    ST_EXEC       = 3'd4,
    ST_MEM        = 3'd5,
    ST_WB         = 3'd6,
    ST_HALT_FAULT = 3'd7
  } cu_state_t;

  // Address source selected on the bus while mem_req is high.
  typedef enum logic [1:0] {
    SEL_PC     = 2'd0,
    SEL_VEC_SP = 2'd1,
    SEL_VEC_PC = 2'd2,
    SEL_DATA   = 2'd3
  } mem_sel_t;

  // Reset vector table: initial SP at 0x0, reset handler address at 0x4.
  localparam logic [31:0] VEC_SP_ADDR = 32'h0000_0000;
  localparam logic [31:0] VEC_PC_ADDR = 32'h0000_0004;

  // True for every state that owns a bus transfer.
  function automatic logic is_mem_state(input cu_state_t s);
    return (s == ST_RST_SP) || (s == ST_RST_PC) ||
           (s == ST_FETCH)  || (s == ST_MEM);
  endfunction

endpackage

// File: rtl/cm0_ctrl_sequencer_if.sv
// Memory handshake bundle between the control sequencer (master) and the
// bus interface (slave). mem_addr_sel uses the mem_sel_t codes.
interface cm0_ctrl_sequencer_if;

  logic       mem_req;
  logic       mem_we;
  logic [1:0] mem_addr_sel;
  logic       mem_ack;

  modport master (
    output mem_req,
    output mem_we,
    output mem_addr_sel,
    input  mem_ack
  );

  modport slave (
    input  mem_req,
    input  mem_we,
    input  mem_addr_sel,
    output mem_ack
  );

endinterface

// File: rtl/cm0_mem_timeout.sv
// Wait-state watchdog for a single memory transfer.
// Counts cycles spent requesting without an ack; 'expired' is raised in the
// cycle the count equals MEM_TIMEOUT and no ack is present, so a late ack in
// that very cycle still wins. MEM_TIMEOUT=0 disables the watchdog.
// MEM_TIMEOUT must be smaller than 2**TMO_W.
module cm0_mem_timeout #(
  parameter int unsigned MEM_TIMEOUT = 16,
  parameter int unsigned TMO_W       = 8
) (
  input  logic clk,
  input  logic rst_n,
  input  logic active,
  input  logic ack,
  output logic expired
);

  localparam logic [TMO_W-1:0] TMO_LIMIT = TMO_W'(MEM_TIMEOUT);
  localparam logic [TMO_W-1:0] CNT_MAX   = '1;

  logic [TMO_W-1:0] cnt_reg;
  logic [TMO_W-1:0] cnt_next;

  // Next count: clear on ack or when no transfer is pending, else saturate-increment.
  always_comb begin
    cnt_next = cnt_reg;
    if (!active || ack) begin
      cnt_next = '0;
    end else if (cnt_reg != CNT_MAX) begin
      cnt_next = cnt_reg + TMO_W'(1);
    end
  end

  // Wait-cycle counter register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_reg <= '0;
    end else begin
      cnt_reg <= cnt_next;
    end
  end

  generate
    if (MEM_TIMEOUT == 0) begin : g_no_timeout
      assign expired = 1'b0;
    end else begin : g_timeout
      assign expired = active && !ack && (cnt_reg == TMO_LIMIT);
    end
  endgenerate

endmodule

// File: rtl/cm0_ctrl_sequencer.sv
// Cortex-M0 multi-cycle control sequencer.
// Boots through the reset vector (SP, then PC), then loops
// FETCH/DECODE/EXEC/[MEM]/WB, driving register-file, PSR and PRIMASK load
// enables. Bus transfers use a req/ack handshake guarded by cm0_mem_timeout;
// a timeout lands in a sticky FAULT that only reset clears.
// All strobes are combinational decodes of registered state and are forced
// low while rst_n is low, so reset aborts a transfer immediately.
// Optional build macro CU_PERF_CNT_EN adds cyc_cnt/instr_cnt counters.
module cm0_ctrl_sequencer
  import cm0_ctrl_pkg::*;
#(
  parameter int unsigned MEM_TIMEOUT = 16,
  parameter int unsigned TMO_W       = 8,
  parameter int unsigned CNT_W       = 32
) (
  input  logic                  clk,
  input  logic                  rst_n,
  cm0_ctrl_sequencer_if.master  bus,
  input  logic                  is_load,
  input  logic                  is_store,
  input  logic                  is_branch,
  input  logic                  is_bl,
  input  logic                  is_cps,
  input  logic                  wr_rd,
  input  logic                  wr_flags,
  input  logic                  halt_req,
  output logic                  ld_ir,
  output logic                  pc_inc,
  output logic                  cu_decode,
  output logic                  ld_sp,
  output logic                  ld_lr,
  output logic                  ld_pc,
  output logic                  ld_rd,
  output logic                  ld_apsr,
  output logic                  ld_ipsr,
  output logic                  ld_primask,
  output logic                  halted,
  output logic                  fault,
  output logic [2:0]            state
`ifdef CU_PERF_CNT_EN
  ,
  output logic [CNT_W-1:0]      cyc_cnt,
  output logic [CNT_W-1:0]      instr_cnt
`endif
);

  cu_state_t state_reg;
  cu_state_t state_next;
  logic      fault_reg;
  logic      fault_next;
  logic      ipsr_done_reg;
  logic      ipsr_done_next;

  logic      mem_active;
  logic      mem_ack;
  logic      tmo_expired;
  logic      mem_we_c;
  mem_sel_t  sel_c;

  assign mem_ack    = bus.mem_ack;
  assign mem_active = rst_n && is_mem_state(state_reg);

  cm0_mem_timeout #(
    .MEM_TIMEOUT (MEM_TIMEOUT),
    .TMO_W       (TMO_W)
  ) u_timeout (
    .clk     (clk),
    .rst_n   (rst_n),
    .active  (mem_active),
    .ack     (mem_ack),
    .expired (tmo_expired)
  );

  // Next-state and strobe decode; everything defaults low, then reset masks all outputs.
  always_comb begin
    state_next     = state_reg;
    fault_next     = fault_reg;
    ipsr_done_next = ipsr_done_reg;
    mem_we_c       = 1'b0;
    sel_c          = SEL_PC;
    ld_ir          = 1'b0;
    pc_inc         = 1'b0;
    cu_decode      = 1'b0;
    ld_sp          = 1'b0;
    ld_lr          = 1'b0;
    ld_pc          = 1'b0;
    ld_rd          = 1'b0;
    ld_apsr        = 1'b0;
    ld_ipsr        = 1'b0;
    ld_primask     = 1'b0;

    case (state_reg)
      ST_RST_SP: begin
        sel_c = SEL_VEC_SP;
        if (mem_ack) begin
          ld_sp      = 1'b1;
          state_next = ST_RST_PC;
        end else if (tmo_expired) begin
          state_next = ST_HALT_FAULT;
          fault_next = 1'b1;
        end
      end
      ST_RST_PC: begin
        sel_c = SEL_VEC_PC;
        if (mem_ack) begin
          ld_pc      = 1'b1;
          state_next = ST_FETCH;
        end else if (tmo_expired) begin
          state_next = ST_HALT_FAULT;
          fault_next = 1'b1;
        end
      end
      ST_FETCH: begin
        sel_c = SEL_PC;
        if (mem_ack) begin
          ld_ir      = 1'b1;
          pc_inc     = 1'b1;
          state_next = ST_DECODE;
        end else if (tmo_expired) begin
          state_next = ST_HALT_FAULT;
          fault_next = 1'b1;
        end
      end
      ST_DECODE: begin
        cu_decode  = 1'b1;
        state_next = ST_EXEC;
      end
      ST_EXEC: begin
        state_next = (is_load || is_store) ? ST_MEM : ST_WB;
      end
      ST_MEM: begin
        // A load+store encoding behaves as a store on the bus.
        sel_c    = SEL_DATA;
        mem_we_c = is_store;
        if (mem_ack) begin
          state_next = ST_WB;
        end else if (tmo_expired) begin
          state_next = ST_HALT_FAULT;
          fault_next = 1'b1;
        end
      end
      ST_WB: begin
        // A load+store encoding is a store, so it never writes Rd from memory.
        ld_rd      = wr_rd || (is_load && !is_store);
        ld_apsr    = wr_flags;
        ld_pc      = is_branch;
        ld_lr      = is_bl;
        ld_primask = is_cps;
        state_next = halt_req ? ST_HALT_FAULT : ST_FETCH;
      end
      ST_HALT_FAULT: begin
        if (fault_reg) begin
          ld_ipsr        = !ipsr_done_reg;
          ipsr_done_next = 1'b1;
        end else if (!halt_req) begin
          state_next = ST_FETCH;
        end
      end
      default: begin
        state_next = ST_RST_SP;
      end
    endcase

    if (!rst_n) begin
      mem_we_c   = 1'b0;
      sel_c      = SEL_PC;
      ld_ir      = 1'b0;
      pc_inc     = 1'b0;
      cu_decode  = 1'b0;
      ld_sp      = 1'b0;
      ld_lr      = 1'b0;
      ld_pc      = 1'b0;
      ld_rd      = 1'b0;
      ld_apsr    = 1'b0;
      ld_ipsr    = 1'b0;
      ld_primask = 1'b0;
    end
  end

  // FSM state, sticky fault flag and one-shot IPSR marker.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg     <= ST_RST_SP;
      fault_reg     <= 1'b0;
      ipsr_done_reg <= 1'b0;
    end else begin
      state_reg     <= state_next;
      fault_reg     <= fault_next;
      ipsr_done_reg <= ipsr_done_next;
    end
  end

  assign bus.mem_req      = mem_active;
  assign bus.mem_we       = mem_we_c;
  assign bus.mem_addr_sel = sel_c;

  assign state  = state_reg;
  assign fault  = fault_reg;
  assign halted = (state_reg == ST_HALT_FAULT) && !fault_reg;

`ifdef CU_PERF_CNT_EN
  logic [CNT_W-1:0] cyc_cnt_reg;
  logic [CNT_W-1:0] instr_cnt_reg;

  // Free-running cycle and retired-instruction counters, wrapping naturally.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cyc_cnt_reg   <= '0;
      instr_cnt_reg <= '0;
    end else begin
      if (state_reg != ST_HALT_FAULT) begin
        cyc_cnt_reg <= cyc_cnt_reg + CNT_W'(1);
      end
      if (state_reg == ST_WB) begin
        instr_cnt_reg <= instr_cnt_reg + CNT_W'(1);
      end
    end
  end

  assign cyc_cnt   = cyc_cnt_reg;
  assign instr_cnt = instr_cnt_reg;
`endif

endmodule

// File: doc/cm0_ctrl_sequencer.md
Name: cm0_ctrl_sequencer

Overview:
Multi-cycle control sequencer for the Cortex-M0 core, replacing the free-running test counter that generates register-load strobes.
- Runs a real reset-vector sequence, then a FETCH/DECODE/EXECUTE/MEM/WRITEBACK loop driven by decoded instruction class.
- Uses a req/ack memory handshake with a parametrised timeout, plus halt and fault handling.
- Sits between the decoder, the register file/PSR/PRIMASK load enables and the bus interface.

Parameters:
MEM_TIMEOUT, 16, max cycles waiting for mem_ack before FAULT; 0 disables the timeout.
TMO_W, 8, width of the timeout counter; must satisfy MEM_TIMEOUT < 2**TMO_W.
CNT_W, 32, width of the performance counters (optional feature).

Ports:
clk  in  1  core clock, all state on rising edge
rst_n  in  1  asynchronous active-low reset
mem_req  out  1  memory request, held until ack
mem_we  out  1  write qualifier, valid while mem_req=1
mem_addr_sel  out  2  address source: 0=PC, 1=VEC_SP (0x0), 2=VEC_PC (0x4), 3=DATA
mem_ack  in  1  transfer complete, sampled while mem_req=1
is_load  in  1  decoded: load
is_store  in  1  decoded: store
is_branch  in  1  decoded: PC write
is_bl  in  1  decoded: link write
is_cps  in  1  decoded: PRIMASK write
wr_rd  in  1  decoded: Rd write
wr_flags  in  1  decoded: APSR update
halt_req  in  1  debug halt request
ld_ir  out  1  capture instruction word
pc_inc  out  1  PC += 2
cu_decode  out  1  decode strobe
ld_sp  out  1  SP load enable
ld_lr  out  1  LR load enable
ld_pc  out  1  PC load enable
ld_rd  out  1  Rd load enable
ld_apsr  out  1  APSR load enable
ld_ipsr  out  1  IPSR load enable
ld_primask  out  1  PRIMASK load enable
halted  out  1  core in HALT
fault  out  1  core in FAULT (sticky)
state  out  3  current FSM state encoding

Behaviour:
- **States:** RST_SP=0, RST_PC=1, FETCH=2, DECODE=3, EXEC=4, MEM=5, WB=6, HALT/FAULT=7.
  - bit `halted` and `fault` distinguish state 7; encoding 7 is reported with fault priority.
- **Reset:** rst_n low → state RST_SP, timeout counter 0, fault=0, halted=0; all strobes 0 immediately.
  - All strobes are combinational decodes of registered state and inputs, so reset mid-operation aborts any transfer (mem_req drops asynchronously).
- **RST_SP:** mem_req=1, sel=1. On ack: ld_sp=1 that cycle, go to RST_PC.
- **RST_PC:** mem_req=1, sel=2. On ack: ld_pc=1, go to FETCH.
- **FETCH:** mem_req=1, sel=0. On ack: ld_ir=1 and pc_inc=1, go to DECODE.
- **DECODE:** cu_decode=1 for exactly one cycle, go to EXEC.
- **EXEC:** (is_load|is_store) → MEM; else → WB. is_load and is_store both set: treated as store.
- **MEM:** mem_req=1, sel=3, mem_we=is_store. On ack → WB.
- **WB:** single cycle; all enables below may assert in the same cycle.
  - ld_rd = wr_rd|is_load
  - ld_apsr = wr_flags
  - ld_pc = is_branch
  - ld_lr = is_bl
  - ld_primask = is_cps
  - Next state: halt_req=1 → HALT, else FETCH.
- **Handshake:**
  - mem_req is asserted in the first cycle of a memory state and remains high until the edge after ack.
  - Same-cycle ack is legal (single-cycle transfer).
  - ack while mem_req=0 is ignored.
  - mem_we=0 outside MEM.
- **Timeout:**
  - Counter increments each memory-state cycle without ack and clears on ack or state exit.
  - If MEM_TIMEOUT≠0 and the counter equals MEM_TIMEOUT with no ack → FAULT.
  - An ack arriving in the same cycle the counter reaches MEM_TIMEOUT wins (no fault).
- **FAULT:** ld_ipsr=1 for the first FAULT cycle only; then fault=1, mem_req=0. Exit only via reset.
- **HALT:** halted=1, no strobes. halt_req=0 → FETCH next edge. halt_req is ignored outside WB.

Optional Feature:
CU_PERF_CNT_EN:
- **Defined:** adds outputs cyc_cnt[CNT_W] and instr_cnt[CNT_W], both reset to 0.
  - cyc_cnt increments every cycle except in HALT/FAULT.
  - instr_cnt increments on each WB cycle.
  - Both wrap modulo 2**CNT_W.
- **Undefined:** no counter ports and no counter logic.

Decomposition:
- **Package cm0_ctrl_pkg:**
  - state encodings
  - mem_addr_sel codes (SEL_PC, SEL_VEC_SP, SEL_VEC_PC, SEL_DATA)
  - vector address constants 0x0/0x4
- **Sub-module cm0_mem_timeout:** counter + compare, inputs active/ack, output expired. It is the only natural split.

Test Plan:
1. **Reset boot:** release rst_n, ack every request with 0 wait → ld_sp pulse in cycle 1, ld_pc pulse in cycle 2, ld_ir in cycle 3, cu_decode in cycle 4.
2. **ALU op:** wr_rd=1, wr_flags=1, ack delay 0 → FETCH→DECODE→EXEC→WB in 4 cycles; ld_rd and ld_apsr both high in WB; mem_req low in EXEC and WB.
3. **Load/store with waits:** load with 3-cycle ack delay → mem_req high 4 cycles with sel=3, mem_we=0, then ld_rd in WB. Store → mem_we=1, ld_rd=0.
4. **BL and CPS:** is_bl=1, is_branch=1 → ld_pc and ld_lr in the same WB cycle. is_cps=1 → ld_primask only.
5. **Timeout:** MEM_TIMEOUT=4, never ack in FETCH → FAULT after 4 waiting cycles; ld_ipsr pulses once; fault sticky; mem_req=0. Ack on exactly cycle 4 → no fault.
6. **Halt and reset abort:**
   - halt_req=1 during WB → halted=1, no strobes for 10 cycles; drop halt_req → FETCH next cycle.
   - Assert rst_n low mid-MEM → mem_req falls immediately, state=RST_SP.
